// File: rtl/freq_meter_if.sv
// -----------------------------------------------------------------------------
// freq_meter_if
//   Register-side bundle of the frequency meter. The meter is the master and
//   drives the results. The register wrapper (or a testbench) is the slave and
//   drives the enable.
//
//   en          slave -> master  level enable
//   period_out  master -> slave  averaged period, in clk cycles
//   high_out    master -> slave  averaged high time, in clk cycles
//   valid       master -> slave  one-cycle pulse when the results update
//   timeout     master -> slave  sticky flag, input stalled past the limit
//   busy        master -> slave  meter is armed or measuring
// -----------------------------------------------------------------------------
interface freq_meter_if;
  logic        en;
  logic [31:0] period_out;
  logic [31:0] high_out;
  logic        valid;
  logic        timeout;
  logic        busy;

  modport master (
    input  en,
    output period_out, high_out, valid, timeout, busy
  );

  modport slave (
    output en,
    input  period_out, high_out, valid, timeout, busy
  );
endinterface

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//   Measures the period and high time of an external square wave, counted in
//   100 MHz clock cycles. It averages 2^AVG_LOG2 consecutive periods per result.
//   The value reads back in divider-control-word units: a wave that toggles
//   every N/2 cycles reads back as N.
//
//   clk_100mhz  in   system clock
//   rst         in   synchronous, active-low reset
//   sig_in      in   measured signal, asynchronous to clk_100mhz
//   bus         --   freq_meter_if.master (en in; period_out, high_out, valid,
//                    timeout, busy out)
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int unsigned TIMEOUT_CYC = 100_000_000,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic         clk_100mhz,
  input  logic         rst,
  input  logic         sig_in,
  freq_meter_if.master bus
);

  localparam int unsigned ACC_W = 32 + AVG_LOG2;
  localparam int unsigned IDX_W = AVG_LOG2 + 1;
  localparam logic [31:0]      TMO      = 32'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t state, state_next;

  // Input conditioning: two flops for metastability, one more flop for edge
  // detection. The fixed latency is the same for both edges, so it cancels.
  logic sync_meta, sync_sig, sync_prev;
  logic rise_p, fall_p;

  logic [31:0]      per_cnt, hi_cnt, per_next, hi_next;
  logic             fell;
  logic [ACC_W-1:0] per_acc, hi_acc;
  logic [IDX_W-1:0] idx;

  logic [31:0] period_q, high_q;
  logic        valid_q, timeout_q;

  logic arm_timeout, meas_timeout, batch_end;

  // NOTE: all clocked state is written with non-blocking assignments, so every
  // flop samples the values from before the edge no matter what order the
  // statements are in.
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_sig  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      sync_sig  <= sync_meta;
      sync_prev <= sync_sig;
    end
  end

  assign rise_p = sync_sig & ~sync_prev;
  assign fall_p = ~sync_sig & sync_prev;

  // The counters saturate at the timeout value instead of wrapping.
  // The high counter stops at the first fall of the period.
  assign per_next = (per_cnt >= TMO) ? TMO : per_cnt + 32'd1;
  assign hi_next  = (sync_sig && !fell && hi_cnt < TMO) ? hi_cnt + 32'd1 : hi_cnt;

  always_ff @(posedge clk_100mhz) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every signal assigned here gets a default first. A path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    arm_timeout  = 1'b0;
    meas_timeout = 1'b0;
    batch_end    = 1'b0;
    if (!bus.en) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: state_next = ARM;
        ARM: begin
          // If an edge arrives on the boundary cycle, the edge is taken.
          if (rise_p)              state_next = MEASURE;
          else if (per_cnt == TMO) arm_timeout = 1'b1;
        end
        MEASURE: begin
          if (rise_p) begin
            if (idx == LAST_IDX) begin
              batch_end  = 1'b1;
              state_next = DONE;
            end
          end else if (per_cnt == TMO) begin
            meas_timeout = 1'b1;
            state_next   = ARM;
          end
        end
        DONE:    state_next = MEASURE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath. A rise always restarts the counters at 1, because the rise
  // cycle itself is the first cycle of the new period. Entry into ARM also
  // loads per_cnt with 1, so ARM times out after exactly TIMEOUT_CYC cycles.
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      per_cnt   <= '0;
      hi_cnt    <= '0;
      fell      <= 1'b0;
      per_acc   <= '0;
      hi_acc    <= '0;
      idx       <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.en) begin
        per_cnt   <= '0;
        hi_cnt    <= '0;
        fell      <= 1'b0;
        per_acc   <= '0;
        hi_acc    <= '0;
        idx       <= '0;
        timeout_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            per_cnt <= 32'd1;
            hi_cnt  <= '0;
            fell    <= 1'b0;
          end
          ARM: begin
            if (rise_p) begin
              per_cnt <= 32'd1;
              hi_cnt  <= 32'd1;
              fell    <= 1'b0;
              per_acc <= '0;
              hi_acc  <= '0;
              idx     <= '0;
            end else if (arm_timeout) begin
              timeout_q <= 1'b1;
              per_cnt   <= 32'd1;
            end else begin
              per_cnt <= per_next;
            end
          end
          MEASURE: begin
            if (rise_p) begin
              per_acc <= per_acc + ACC_W'(per_cnt);
              hi_acc  <= hi_acc + ACC_W'(hi_cnt);
              idx     <= batch_end ? '0 : idx + 1'b1;
              per_cnt <= 32'd1;
              hi_cnt  <= 32'd1;
              fell    <= 1'b0;
            end else if (meas_timeout) begin
              timeout_q <= 1'b1;
              per_acc   <= '0;
              hi_acc    <= '0;
              idx       <= '0;
              per_cnt   <= 32'd1;
              hi_cnt    <= '0;
              fell      <= 1'b0;
            end else begin
              per_cnt <= per_next;
              hi_cnt  <= hi_next;
              if (fall_p) fell <= 1'b1;
            end
          end
          DONE: begin
            // The closing rise of this batch has already opened the next
            // period, so the counters keep running through this cycle.
            period_q  <= 32'(per_acc >> AVG_LOG2);
            high_q    <= 32'(hi_acc >> AVG_LOG2);
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
            per_acc   <= '0;
            hi_acc    <= '0;
            per_cnt   <= per_next;
            hi_cnt    <= hi_next;
            if (fall_p) fell <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.period_out = period_q;
  assign bus.high_out   = high_q;
  assign bus.valid      = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = (state == ARM) || (state == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//   Drives two meters (AVG_LOG2 = 2 and AVG_LOG2 = 1, TIMEOUT_CYC = 1000) from
//   one square-wave source. The wave is described as a list of
//   (high, low) segments, and each segment starts with a rising edge. The
//   reference model treats every segment except the last as one complete
//   period of high+low cycles. It then averages consecutive groups of periods.
// -----------------------------------------------------------------------------
module tb_freq_meter;
  localparam int TMO = 1000;

  logic clk_100mhz = 1'b0;
  logic rst        = 1'b0;
  logic sig_in     = 1'b0;
  logic en         = 1'b0;

  always #5 clk_100mhz = ~clk_100mhz;

  freq_meter_if bus4 ();
  freq_meter_if bus2 ();
  assign bus4.en = en;
  assign bus2.en = en;

  freq_meter #(.TIMEOUT_CYC(TMO), .AVG_LOG2(2)) dut4 (
    .clk_100mhz(clk_100mhz), .rst(rst), .sig_in(sig_in), .bus(bus4));
  freq_meter #(.TIMEOUT_CYC(TMO), .AVG_LOG2(1)) dut2 (
    .clk_100mhz(clk_100mhz), .rst(rst), .sig_in(sig_in), .bus(bus2));

  typedef struct {
    int unsigned per;
    int unsigned hi;
    int unsigned cyc;
  } res_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  res_t        got4[$], got2[$], exp4[$], exp2[$];
  int unsigned seg_h[$], seg_l[$];
  int unsigned last_per4 = 0, last_hi4 = 0;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Capture every result pulse, sampled away from the active edge.
  always @(negedge clk_100mhz) begin
    if (bus4.valid === 1'b1) got4.push_back(res_t'{bus4.period_out, bus4.high_out, cyc});
    if (bus2.valid === 1'b1) got2.push_back(res_t'{bus2.period_out, bus2.high_out, cyc});
  end

  // ---------------- stimulus helpers ----------------
  task automatic play_list();
    for (int i = 0; i < seg_h.size(); i++) begin
      sig_in = 1'b1;
      repeat (seg_h[i]) @(negedge clk_100mhz);
      sig_in = 1'b0;
      repeat (seg_l[i]) @(negedge clk_100mhz);
    end
    repeat (10) @(negedge clk_100mhz);
  endtask

  task automatic start_run();
    en = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    got4.delete(); got2.delete(); seg_h.delete(); seg_l.delete();
    en = 1'b1;
    repeat (3) @(negedge clk_100mhz);
  endtask

  task automatic add_seg(input int unsigned h, input int unsigned l);
    seg_h.push_back(h);
    seg_l.push_back(l);
  endtask

  // ---------------- reference model ----------------
  function automatic res_t avg_of(input int first, input int log2);
    longint unsigned sp = 0, sh = 0;
    res_t r;
    for (int i = first; i < first + (1 << log2); i++) begin
      sp += seg_h[i] + seg_l[i];
      sh += seg_h[i];
    end
    r.per = int'(sp >> log2);
    r.hi  = int'(sh >> log2);
    r.cyc = 0;
    return r;
  endfunction

  task automatic build_model();
    int n;
    exp4.delete(); exp2.delete();
    n = seg_h.size() - 1;
    for (int b = 0; (b + 1) * 4 <= n; b++) exp4.push_back(avg_of(b * 4, 2));
    for (int b = 0; (b + 1) * 2 <= n; b++) exp2.push_back(avg_of(b * 2, 1));
    if (exp4.size() > 0) begin
      last_per4 = exp4[exp4.size() - 1].per;
      last_hi4  = exp4[exp4.size() - 1].hi;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    n_checks++;
    if ({bus4.period_out, bus4.high_out, bus4.valid, bus4.timeout, bus4.busy} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_outs4: got per=%0d hi=%0d v=%b t=%b b=%b, expected all 0",
               bus4.period_out, bus4.high_out, bus4.valid, bus4.timeout, bus4.busy);
    end
    n_checks++;
    if ({bus2.period_out, bus2.high_out, bus2.valid, bus2.timeout, bus2.busy} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_outs2: got per=%0d hi=%0d v=%b t=%b b=%b, expected all 0",
               bus2.period_out, bus2.high_out, bus2.valid, bus2.timeout, bus2.busy);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    n_checks++;
    if (bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b, expected 0 with en low", bus4.busy);
    end
  endtask

  task automatic test_square();
    int unsigned t0;
    start_run();
    for (int i = 0; i < 9; i++) add_seg(50, 50);
    t0 = cyc;
    play_list();
    build_model();
    n_checks++;
    if (got4.size() != exp4.size() || got2.size() != exp2.size()) begin
      n_fail++;
      $display("FAIL sq_count: got %0d/%0d results, expected %0d/%0d",
               got4.size(), got2.size(), exp4.size(), exp2.size());
    end
    for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
      n_checks++;
      if (got4[i].per !== exp4[i].per || got4[i].hi !== exp4[i].hi) begin
        n_fail++;
        $display("FAIL sq_res4[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got4[i].per, got4[i].hi, exp4[i].per, exp4[i].hi);
      end
    end
    for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
      n_checks++;
      if (got2[i].per !== exp2[i].per || got2[i].hi !== exp2[i].hi) begin
        n_fail++;
        $display("FAIL sq_res2[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got2[i].per, got2[i].hi, exp2[i].per, exp2[i].hi);
      end
    end
    if (got4.size() >= 2) begin
      n_checks++;
      if (got4[0].per !== 100 || got4[0].hi !== 50) begin
        n_fail++;
        $display("FAIL sq_value: got %0d/%0d, expected 100/50", got4[0].per, got4[0].hi);
      end
      n_checks++;
      if (got4[0].cyc - t0 > 5 * 100 + 4) begin
        n_fail++;
        $display("FAIL sq_latency: got %0d cycles, expected <= 504", got4[0].cyc - t0);
      end
      n_checks++;
      if (got4[1].cyc - got4[0].cyc !== 400) begin
        n_fail++;
        $display("FAIL sq_spacing: got %0d cycles, expected 400", got4[1].cyc - got4[0].cyc);
      end
    end
  endtask

  task automatic test_alternating();
    start_run();
    for (int i = 0; i < 9; i++) add_seg(50, (i % 2 == 0) ? 50 : 53);
    play_list();
    build_model();
    n_checks++;
    if (got2.size() != exp2.size() || got4.size() != exp4.size()) begin
      n_fail++;
      $display("FAIL alt_count: got %0d/%0d results, expected %0d/%0d",
               got4.size(), got2.size(), exp4.size(), exp2.size());
    end
    for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
      n_checks++;
      if (got2[i].per !== exp2[i].per || got2[i].hi !== exp2[i].hi) begin
        n_fail++;
        $display("FAIL alt_res2[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got2[i].per, got2[i].hi, exp2[i].per, exp2[i].hi);
      end
    end
    for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
      n_checks++;
      if (got4[i].per !== exp4[i].per || got4[i].hi !== exp4[i].hi) begin
        n_fail++;
        $display("FAIL alt_res4[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got4[i].per, got4[i].hi, exp4[i].per, exp4[i].hi);
      end
    end
    if (got2.size() > 0) begin
      n_checks++;
      if (got2[0].per !== 101) begin
        n_fail++;
        $display("FAIL alt_trunc: got %0d, expected 101", got2[0].per);
      end
    end
  endtask

  task automatic test_random();
    int unsigned p;
    start_run();
    for (int i = 0; i < 25; i++) begin
      p = $urandom_range(300, 2);
      add_seg($urandom_range(p - 1, 1), 0);
      seg_l[i] = p - seg_h[i];
    end
    play_list();
    build_model();
    n_checks++;
    if (got4.size() != exp4.size() || got2.size() != exp2.size()) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d/%0d results, expected %0d/%0d",
               got4.size(), got2.size(), exp4.size(), exp2.size());
    end
    for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
      n_checks++;
      if (got4[i].per !== exp4[i].per || got4[i].hi !== exp4[i].hi) begin
        n_fail++;
        $display("FAIL rnd_res4[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got4[i].per, got4[i].hi, exp4[i].per, exp4[i].hi);
      end
    end
    for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
      n_checks++;
      if (got2[i].per !== exp2[i].per || got2[i].hi !== exp2[i].hi) begin
        n_fail++;
        $display("FAIL rnd_res2[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got2[i].per, got2[i].hi, exp2[i].per, exp2[i].hi);
      end
    end
  endtask

  task automatic test_timeout();
    int unsigned busy_low = 0;
    en = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    got4.delete(); got2.delete(); seg_h.delete(); seg_l.delete();
    en = 1'b1;
    repeat (1000) begin
      @(negedge clk_100mhz);
      if (bus4.busy !== 1'b1 || bus2.busy !== 1'b1) busy_low++;
    end
    n_checks++;
    if (bus4.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: got %b, expected 0 at 999 cycles into ARM", bus4.timeout);
    end
    @(negedge clk_100mhz);
    n_checks++;
    if (bus4.timeout !== 1'b1 || bus2.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_set: got %b/%b, expected 1/1 at 1000 cycles into ARM",
               bus4.timeout, bus2.timeout);
    end
    repeat (1500) begin
      @(negedge clk_100mhz);
      if (bus4.busy !== 1'b1 || bus2.busy !== 1'b1) busy_low++;
    end
    n_checks++;
    if (busy_low !== 0) begin
      n_fail++;
      $display("FAIL tmo_busy: got %0d cycles with busy low, expected 0", busy_low);
    end
    n_checks++;
    if (got4.size() + got2.size() !== 0 || bus4.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_hold: got %0d valids timeout=%b, expected 0 valids timeout=1",
               got4.size() + got2.size(), bus4.timeout);
    end
    for (int i = 0; i < 9; i++) add_seg(10, 10);
    play_list();
    build_model();
    n_checks++;
    if (got4.size() != exp4.size() || got2.size() != exp2.size()) begin
      n_fail++;
      $display("FAIL tmo_count: got %0d/%0d results, expected %0d/%0d",
               got4.size(), got2.size(), exp4.size(), exp2.size());
    end
    for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
      n_checks++;
      if (got4[i].per !== exp4[i].per || got4[i].hi !== exp4[i].hi) begin
        n_fail++;
        $display("FAIL tmo_res4[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got4[i].per, got4[i].hi, exp4[i].per, exp4[i].hi);
      end
    end
    n_checks++;
    if (bus4.timeout !== 1'b0 || bus2.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: got %b/%b, expected 0/0 after valid",
               bus4.timeout, bus2.timeout);
    end
  endtask

  task automatic test_en_drop();
    start_run();
    add_seg(60, 40);
    add_seg(60, 40);
    sig_in = 1'b1;
    add_seg(0, 0);
    play_list();
    repeat (20) @(negedge clk_100mhz);
    en = 1'b0;
    @(negedge clk_100mhz);
    n_checks++;
    if (bus4.busy !== 1'b0 || bus2.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_busy: got %b/%b, expected 0/0", bus4.busy, bus2.busy);
    end
    n_checks++;
    if (bus4.period_out !== last_per4 || bus4.high_out !== last_hi4 || got4.size() !== 0) begin
      n_fail++;
      $display("FAIL endrop_hold: got %0d/%0d with %0d valids, expected %0d/%0d with 0",
               bus4.period_out, bus4.high_out, got4.size(), last_per4, last_hi4);
    end
    sig_in = 1'b0;
    start_run();
    for (int i = 0; i < 5; i++) add_seg(30, 15);
    play_list();
    build_model();
    n_checks++;
    if (got4.size() != 1 || exp4.size() != 1) begin
      n_fail++;
      $display("FAIL endrop_count: got %0d results, expected 1", got4.size());
    end else begin
      n_checks++;
      if (got4[0].per !== exp4[0].per || got4[0].hi !== exp4[0].hi) begin
        n_fail++;
        $display("FAIL endrop_res: got %0d/%0d, expected %0d/%0d",
                 got4[0].per, got4[0].hi, exp4[0].per, exp4[0].hi);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_run();
    add_seg(70, 30);
    add_seg(70, 30);
    add_seg(20, 5);
    play_list();
    rst = 1'b0;
    @(negedge clk_100mhz);
    n_checks++;
    if ({bus4.period_out, bus4.high_out, bus4.valid, bus4.timeout, bus4.busy} !== 67'd0 ||
        {bus2.period_out, bus2.high_out, bus2.valid, bus2.timeout, bus2.busy} !== 67'd0) begin
      n_fail++;
      $display("FAIL rstmid_outs: got per=%0d/%0d busy=%b/%b, expected all 0",
               bus4.period_out, bus2.period_out, bus4.busy, bus2.busy);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    got4.delete(); got2.delete(); seg_h.delete(); seg_l.delete();
    for (int i = 0; i < 5; i++) add_seg(40, 25);
    play_list();
    build_model();
    n_checks++;
    if (got4.size() != 1 || exp4.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d results, expected 1", got4.size());
    end else begin
      n_checks++;
      if (got4[0].per !== exp4[0].per || got4[0].hi !== exp4[0].hi) begin
        n_fail++;
        $display("FAIL rstmid_res: got %0d/%0d, expected %0d/%0d",
                 got4[0].per, got4[0].hi, exp4[0].per, exp4[0].hi);
      end
    end
  endtask

  task automatic test_boundary();
    start_run();
    for (int i = 0; i < 4; i++) add_seg(500, 500);
    add_seg(500, 5);
    play_list();
    build_model();
    n_checks++;
    if (got4.size() != exp4.size() || got2.size() != exp2.size()) begin
      n_fail++;
      $display("FAIL bnd_count: got %0d/%0d results, expected %0d/%0d",
               got4.size(), got2.size(), exp4.size(), exp2.size());
    end
    for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
      n_checks++;
      if (got2[i].per !== exp2[i].per || got2[i].hi !== exp2[i].hi) begin
        n_fail++;
        $display("FAIL bnd_res2[%0d]: got %0d/%0d, expected %0d/%0d",
                 i, got2[i].per, got2[i].hi, exp2[i].per, exp2[i].hi);
      end
    end
    if (got4.size() > 0) begin
      n_checks++;
      if (got4[0].per !== 1000 || got4[0].hi !== 500) begin
        n_fail++;
        $display("FAIL bnd_res4: got %0d/%0d, expected 1000/500", got4[0].per, got4[0].hi);
      end
    end
    n_checks++;
    if (bus4.timeout !== 1'b0 || bus2.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_no_tmo: got %b/%b, expected 0/0", bus4.timeout, bus2.timeout);
    end
    repeat (1100) @(negedge clk_100mhz);
    n_checks++;
    if (bus4.timeout !== 1'b1 || bus2.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL bnd_meas_tmo: got %b/%b, expected 1/1 after a stall", bus4.timeout,
               bus2.timeout);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_alternating();
    test_random();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
